dmem_controller: RTL and testbench

Parametrised data-memory controller for the single-cycle and upcoming multi-cycle MIPS datapath. It replaces the word-only, unhandshaked data memory with several additions:
- a byte-addressed, ready/valid request port
- byte/half/word loads and stores with sign or zero extension
- misalignment and range checking
- registered read data
- an optional post-reset memory-clear sequence

It sits between the ALU address output / register-file store data and the write-back mux.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_lane_align.sv | 55 +++++
 rtl/dmem_controller.sv | 120 ++++++++++++
 tb/tb_dmem_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller and its lane aligner:
// access-size encodings, controller FSM states and the response width.
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_R = 2'b11;   // reserved, always rejected

    localparam int RSP_W = 32;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for little-endian 32-bit words.
// Store side: byte enables plus lane-replicated write data.
// Load side: extract addressed lanes, right-align, sign/zero extend.
// Also flags half/word accesses that are not naturally aligned.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]       size,
    input  logic [1:0]       lane,
    input  logic             is_unsigned,
    input  logic [31:0]      wdata,
    input  logic [31:0]      rword,
    output logic [3:0]       be,
    output logic [31:0]      wdata_rep,
    output logic [RSP_W-1:0] rdata,
    output logic             misaligned
);

    logic [31:0] shifted;

    // Addressed lanes moved down to bit 0.
    assign shifted = rword >> {lane, 3'b000};

    // Size/lane decode for both directions.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        be         = 4'b0000;
        wdata_rep  = '0;
        rdata      = '0;
        misaligned = 1'b0;
        case (size)
            SIZE_B: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
                rdata     = is_unsigned ? {24'b0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                be         = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{wdata[15:0]}};
                rdata      = is_unsigned ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
                misaligned = lane[0];
            end
            SIZE_W: begin
                be         = 4'b1111;
                wdata_rep  = wdata;
                rdata      = rword;
                misaligned = (lane != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_controller.sv
// Byte-addressed data memory with ready/valid request port, byte/half/word
// access, range and alignment checking and a registered one-cycle response.
// Define DMEM_CLEAR_EN to zero the whole array after every reset (the port
// stays not-ready for DEPTH cycles); otherwise the port is ready one cycle
// after reset and memory contents start undefined.
module dmem_controller
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [RSP_W-1:0]  rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             out_of_range;
    logic             misaligned;
    logic             req_err;
    logic             store_en;
    logic [3:0]       be;
    logic [31:0]      wdata_rep;
    logic [RSP_W-1:0] load_data;

`ifdef DMEM_CLEAR_EN
    state_t           state;
    logic [IDX_W-1:0] clr_cnt;
`endif

    assign idx          = req_addr[IDX_W+1:2];
    assign accept       = req_valid && req_ready;
    assign out_of_range = (req_addr >> (IDX_W + 2)) != '0;
    assign req_err      = (req_size == SIZE_R) || misaligned || out_of_range;
    assign store_en     = accept && req_we && !req_err;

    dmem_lane_align u_align (
        .size        (req_size),
        .lane        (req_addr[1:0]),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .rword       (mem[idx]),
        .be          (be),
        .wdata_rep   (wdata_rep),
        .rdata       (load_data),
        .misaligned  (misaligned)
    );

    // Array writes: clearing sweep first, otherwise lane-masked stores.
    // The read path is asynchronous, so a load accepted the cycle after a
    // store to the same word already sees the new data.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; contents change only through the clear sweep or stores.
`ifdef DMEM_CLEAR_EN
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else
`endif
        if (store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    // Control FSM with registered ready.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
`ifdef DMEM_CLEAR_EN
        if (reset) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            req_ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: req_ready <= 1'b1;
            endcase
        end
`else
        // Without the clear sweep the FSM is permanently IDLE; only the
        // registered ready flag remains.
        if (reset) req_ready <= 1'b0;
        else       req_ready <= 1'b1;
`endif
    end

    // Response registers: one-cycle pulse per accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept && req_err;
            rsp_rdata <= (accept && !req_we && !req_err) ? load_data : '0;
        end
    end

endmodule

// File: tb/tb_dmem_controller.sv
// Self-checking bench for dmem_controller (DEPTH=16). Directed cases from
// the test plan followed by randomized traffic scored against a byte-array
// reference model. Works with or without DMEM_CLEAR_EN defined.
module tb_dmem_controller;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;
    localparam int NBYTES = DEPTH * 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mb [NBYTES];

    dmem_controller #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: byte-addressed array, access sizes 1/2/4 bytes.
    task automatic model_access(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rd);
        int n;
        logic [31:0] val;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || (addr % n != 0) || (addr >= NBYTES);
        rd  = 32'h0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < n; k++) mb[addr + k] = wdata[8*k +: 8];
            end else begin
                val = 32'h0;
                for (int k = 0; k < n; k++) val = val | (32'(mb[addr + k]) << (8*k));
                if (!uns && n < 4 && val[8*n - 1]) val = val | ~((32'h1 << (8*n)) - 1);
                rd = val;
            end
        end
    endtask

    // Present one request; its response is checked right after the accept edge.
    task automatic issue(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        logic e_err;
        logic [31:0] e_rd;
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        model_access(we, size, uns, addr, wdata, e_err, e_rd);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".err"},   32'(rsp_err),   32'(e_err));
        check({tag, ".rdata"}, rsp_rdata,      e_rd);
    endtask

    task automatic idle_cycle(input string tag);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, ".valid0"}, 32'(rsp_valid), 32'd0);
        check({tag, ".err0"},   32'(rsp_err),   32'd0);
        check({tag, ".rdata0"}, rsp_rdata,      32'd0);
    endtask

    // Release reset and verify when ready rises.
    task automatic release_and_wait(input string tag);
        @(negedge clk);
        reset = 1'b0;
`ifdef DMEM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            check({tag, ".clr_ready"}, 32'(req_ready), (i == DEPTH - 1) ? 32'd1 : 32'd0);
            check({tag, ".clr_valid"}, 32'(rsp_valid), 32'd0);
        end
`else
        @(posedge clk); #1;
        check({tag, ".ready1"}, 32'(req_ready), 32'd1);
`endif
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", 32'(req_ready), 32'd0);
        check("rst.valid", 32'(rsp_valid), 32'd0);
        check("rst.err",   32'(rsp_err),   32'd0);
        check("rst.rdata", rsp_rdata,      32'd0);

`ifdef DMEM_CLEAR_EN
        // A store held during the clear sweep must be ignored.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h0;
        req_wdata = 32'hDEADBEEF;
`endif
        release_and_wait("clr");
`ifndef DMEM_CLEAR_EN
        for (int w = 0; w < DEPTH; w++) issue("init", 1'b1, 2'b10, 1'b0, 32'(w * 4), 32'h0);
`endif

        issue("lw3c", 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
        issue("lw00", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
        idle_cycle("idle0");

        // Extension cases.
        issue("sw10",  1'b1, 2'b10, 1'b0, 32'h10, 32'h800000F0);
        issue("lb13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        issue("lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        issue("lh12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        issue("lhu12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        issue("lw10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lb13.const",  32'hFFFFFF80, {{24{mb[8'h13][7]}}, mb[8'h13]});

        // Byte/half store merge.
        issue("sw20",  1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
        issue("sb21",  1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AB);
        issue("lw20a", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        check("merge1", rsp_rdata, 32'h1122AB44);
        issue("sh22",  1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF);
        issue("lw20b", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        check("merge2", rsp_rdata, 32'hBEEFAB44);

        // Misaligned, reserved, out of range.
        issue("sw04",  1'b1, 2'b10, 1'b0, 32'h04, 32'h01020304);
        issue("sw06",  1'b1, 2'b10, 1'b0, 32'h06, 32'h5555AAAA);
        check("sw06.err", 32'(rsp_err), 32'd1);
        issue("lw04",  1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
        check("lw04.keep", rsp_rdata, 32'h01020304);
        issue("lh01",  1'b0, 2'b01, 1'b0, 32'h01, 32'h0);
        issue("rsv",   1'b0, 2'b11, 1'b0, 32'h08, 32'h0);
        issue("lw40",  1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        check("lw40.err", 32'(rsp_err), 32'd1);

        // Back-to-back store then load of the same word.
        issue("sw08",  1'b1, 2'b10, 1'b0, 32'h08, 32'hCAFEF00D);
        issue("lw08",  1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
        check("b2b.data", rsp_rdata, 32'hCAFEF00D);
        idle_cycle("idle1");

        // Randomized traffic.
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                idle_cycle("rnd.idle");
            end else begin
                sz = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 9))
                    0:       a = 32'(NBYTES) + 32'($urandom_range(0, 255));
                    1:       a = (32'h1 << $urandom_range(6, 31)) | 32'($urandom_range(0, 63));
                    default: a = 32'($urandom_range(0, NBYTES - 1));
                endcase
                // Bias toward aligned addresses so most requests succeed.
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == 2'b01) a[0] = 1'b0;
                    if (sz == 2'b10) a[1:0] = 2'b00;
                end
                issue("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            end
        end
        idle_cycle("idle2");

        // Reset in the middle of the clear sweep (or plain reset pulse).
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst2.ready", 32'(req_ready), 32'd0);
        check("rst2.valid", 32'(rsp_valid), 32'd0);
`ifdef DMEM_CLEAR_EN
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("mid.ready0", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid.rst_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
`endif
        release_and_wait("mid");
        for (int w = 0; w < DEPTH; w++) issue("post", 1'b0, 2'b10, 1'b0, 32'(w * 4), 32'h0);
        idle_cycle("idle3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
